fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and instruction-fetch stage sitting directly upstream of the control decoder. It sequences the PC through the instruction ROM, resolves branch-class instructions against a 32-entry target table and the registered Zero flag, and presents one 9-bit instruction per cycle to the decoder. It also owns the program start/done handshake with the testbench or top level.

## Interface
Parameters:
- PC_W, 10, PC and ROM address width
- START_PC, 0, PC loaded on Start

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset_n  input  1  synchronous, active-low reset
- Start  input  1  one-cycle request to begin execution at START_PC
- Stall  input  1  hold PC and state this cycle (multi-cycle data-memory access)
- Zero_flag  input  1  registered ALU Zero flag from the most recent CMP/SUB
- Prog_addr  output  PC_W  instruction ROM address (= PC)
- Prog_data  input  9  instruction ROM read data, combinational from Prog_addr
- Instruction  output  9  instruction to the decoder
- Instr_valid  output  1  Instruction is live and may commit
- Done  output  1  one-cycle pulse when HALT is fetched
- Busy  output  1  high while in RUN

## Operation
- Branch class: Instruction[8]=0 and Instruction[6]=1; the decoder asserts no enables for this class.
  - Instruction[7]=1: unconditional.
  - Instruction[7]=0, Instruction[5]=0: taken if Zero_flag=1 (BEQ).
  - Instruction[7]=0, Instruction[5]=1: taken if Zero_flag=0 (BNE).
  - Instruction[4:0]: index into the branch target table.
- HALT = unconditional branch with index 31 (9'h0FF). It is never taken as a jump; table entry 31 is unused.
- States:
  - IDLE, the reset state: PC=START_PC. Start moves to RUN.
  - RUN: next PC is PC when Stall=1; target when a branch is taken; PC+1 otherwise. Fetching HALT with Stall=0 pulses Done and moves to HALTED with PC held.
  - HALTED: PC held. Start reloads START_PC and moves to RUN.
- Start is ignored in RUN.
- Outputs:
  - Instruction = Prog_data in RUN; the NOP 9'h040 (branch class, decoder-inert) in IDLE and HALTED.
  - Instr_valid = RUN & ~Stall.
  - Busy = RUN.
- PC arithmetic is modulo 2^PC_W: PC+1 at all-ones wraps to 0, with no flag.
- Branch targets are PC_W bits, zero-extended from table constants.

## Timing
- Reset values, applied on the first rising edge of Clk with Reset_n=0 and overriding every other input:
  - state=IDLE, PC=START_PC.
  - Done=0, Busy=0, Instr_valid=0.
  - Instruction=9'h040, Prog_addr=START_PC.
- Start sampled high in IDLE: RUN from the next cycle, with the first instruction ROM[START_PC] valid in that cycle.
- Fetch latency is 0 cycles: Instruction is combinational from PC.
- One instruction retires per non-stalled RUN cycle.
- Taken branch: the target instruction appears the very next cycle. There is no delay slot and no bubble.
- Zero_flag is sampled in the same cycle the branch instruction is on Instruction. A CMP immediately preceding the branch must already have updated the flag at the edge between them.
- Stall=1 together with a branch or HALT: Stall wins. Nothing updates, Done stays low, and the instruction is re-evaluated the next cycle.
- Done is high for exactly one cycle, the cycle HALT is presented. Busy falls on the following cycle.
- Reset_n low mid-RUN: IDLE on the next edge. No Done is issued.
- Start and Reset_n=0 in the same cycle: reset wins.

## Structure
- Shared package (definitions) holds:
  - fetch_state_t enum {IDLE, RUN, HALTED}.
  - Branch field constants: BR_UNCOND_BIT=7, BR_NE_BIT=5, BR_IDX_W=5.
  - HALT_IDX=31 and NOP_INSTR=9'h040.
- Sub-module branch_lut: combinational, 5-bit index in, PC_W-bit target out, program-specific case table. It is swapped per program image without touching fetch_unit.
- Everything else (PC register, state register, next-PC mux) is in fetch_unit.

## Test plan
- Reset and start: hold Reset_n=0 for 2 cycles, then Start pulse with START_PC=0 → Busy=1 the next cycle, Prog_addr steps 0,1,2,3, Instr_valid=1, Instruction equals the ROM contents.
- Conditional branches: ROM[5]=BEQ idx 2 with lut[2]=20.
  - Zero_flag=1 → PC goes 5→20.
  - Repeat with Zero_flag=0 → PC goes 5→6.
  - Same pair for BNE with the outcomes inverted.
- Stall: assert Stall for 3 cycles while PC=7 holds a taken branch → PC stays 7 and Instr_valid=0 throughout; jump occurs on the first cycle after Stall drops.
- HALT: ROM[12]=9'h0FF → Done high for exactly 1 cycle while Prog_addr=12, then state HALTED, Instruction=9'h040, Busy=0. A later Start restarts at 0.
- Wrap: PC_W=4, straight-line ROM → PC goes 15→0 with no Done.
- Reset mid-run: Reset_n=0 at PC=9 → the next cycle shows IDLE, PC=START_PC, Done=0. Start issued in the same cycle as reset is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, branch field layout
// and the special HALT/NOP encodings.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int BR_UNCOND_BIT = 7;
  localparam int BR_NE_BIT     = 5;
  localparam int BR_IDX_W      = 5;

  localparam logic [BR_IDX_W-1:0] HALT_IDX  = 5'd31;
  localparam logic [8:0]          NOP_INSTR = 9'h040;

  // Branch class: bit 8 clear, bit 6 set.
  function automatic logic is_branch(input logic [8:0] instr);
    return ~instr[8] & instr[6];
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Program-specific branch target table; replaced per program image.
// Entry 31 is the HALT index and is never used as a jump target.
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [BR_IDX_W-1:0] idx_i,
  output logic [PC_W-1:0]     target_o
);

  logic [9:0] raw;

  always_comb begin
    raw = 10'd0;
    case (idx_i)
      5'd2:    raw = 10'd20;
      5'd3:    raw = 10'd6;
      5'd4:    raw = 10'd8;
      default: raw = 10'd0;
    endcase
  end

  // Table constants are zero-extended (or truncated) to the PC width.
  assign target_o = PC_W'(raw);

endmodule

// File: rtl/fetch_unit.sv
// PC sequencer and instruction fetch: steps the PC through the ROM, resolves
// branches against the target table and Zero flag, and runs start/done.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Zero_flag,
  output logic [PC_W-1:0] Prog_addr,
  input  logic [8:0]      Prog_data,
  output logic [8:0]      Instruction,
  output logic            Instr_valid,
  output logic            Done,
  output logic            Busy
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] br_target;
  logic            br_cls, br_cond, br_taken, is_halt;

  branch_lut #(.PC_W(PC_W)) u_lut (
    .idx_i    (Prog_data[BR_IDX_W-1:0]),
    .target_o (br_target)
  );

  // Decode straight from ROM data; only acted on while in RUN.
  assign br_cls   = is_branch(Prog_data);
  assign br_cond  = Prog_data[BR_NE_BIT] ? ~Zero_flag : Zero_flag;
  assign br_taken = br_cls & (Prog_data[BR_UNCOND_BIT] | br_cond);
  assign is_halt  = br_cls & Prog_data[BR_UNCOND_BIT]
                  & (Prog_data[BR_IDX_W-1:0] == HALT_IDX);

  assign Prog_addr = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    Instruction = NOP_INSTR;
    Instr_valid = 1'b0;
    Done        = 1'b0;
    Busy        = 1'b0;
    case (state_q)
      RUN: begin
        Busy        = 1'b1;
        Instruction = Prog_data;
        Instr_valid = ~Stall;
        if (!Stall) begin
          if (is_halt) begin
            Done    = 1'b1;
            state_d = HALTED;
          end else if (br_taken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        // IDLE and HALTED both wait for Start and restart from START_PC.
        if (Start) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a spec-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0, Stall = 1'b0, Zero_flag = 1'b0;
  logic [9:0] Prog_addr;
  logic [8:0] Prog_data, Instruction;
  logic       Instr_valid, Done, Busy;

  logic       Start2 = 1'b0;
  logic [3:0] Prog_addr2;
  logic [8:0] Prog_data2, Instruction2;
  logic       Instr_valid2, Done2, Busy2;

  logic [8:0] rom  [0:1023];
  logic [8:0] rom2 [0:15];
  int         lut_m [0:31];

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  assign Prog_data  = rom[Prog_addr];
  assign Prog_data2 = rom2[Prog_addr2];

  fetch_unit #(.PC_W(10), .START_PC(10'd0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .Zero_flag(Zero_flag), .Prog_addr(Prog_addr), .Prog_data(Prog_data),
    .Instruction(Instruction), .Instr_valid(Instr_valid), .Done(Done),
    .Busy(Busy)
  );

  fetch_unit #(.PC_W(4), .START_PC(4'd0)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start2), .Stall(1'b0),
    .Zero_flag(1'b0), .Prog_addr(Prog_addr2), .Prog_data(Prog_data2),
    .Instruction(Instruction2), .Instr_valid(Instr_valid2), .Done(Done2),
    .Busy(Busy2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic bit taken(input logic [8:0] ins, input logic z);
    if (ins[8] || !ins[6]) return 1'b0;
    if (ins[7]) return 1'b1;
    return ins[5] ? !z : z;
  endfunction

  // Spec-level model: mode 0 idle, 1 run, 2 halted.
  int         m_mode = 0, m_pc = 0, m2_mode = 0, m2_pc = 0;
  bit         m_ok = 1'b0;
  logic [8:0] m_ins;

  always @(posedge Clk) begin
    if (!Reset_n) begin
      m_mode = 0; m_pc = 0; m2_mode = 0; m2_pc = 0; m_ok = 1'b1;
    end else begin
      if (m_mode != 1) begin
        if (Start) begin m_mode = 1; m_pc = 0; end
      end else if (!Stall) begin
        m_ins = rom[m_pc];
        if (m_ins == 9'h0FF) m_mode = 2;
        else if (taken(m_ins, Zero_flag)) m_pc = lut_m[m_ins[4:0]];
        else m_pc = (m_pc + 1) % 1024;
      end
      if (m2_mode != 1) begin
        if (Start2) begin m2_mode = 1; m2_pc = 0; end
      end else if (rom2[m2_pc] == 9'h0FF) m2_mode = 2;
      else m2_pc = (m2_pc + 1) % 16;
    end
  end

  always @(negedge Clk) begin
    if (m_ok) begin
      chk("m.addr",  Prog_addr,   m_pc);
      chk("m.instr", Instruction, (m_mode == 1) ? rom[m_pc] : 9'h040);
      chk("m.valid", Instr_valid, (m_mode == 1) && !Stall);
      chk("m.done",  Done,        (m_mode == 1) && !Stall && rom[m_pc] == 9'h0FF);
      chk("m.busy",  Busy,        m_mode == 1);
      chk("m2.addr", Prog_addr2,  m2_pc);
      chk("m2.done", Done2,       (m2_mode == 1) && rom2[m2_pc] == 9'h0FF);
      chk("m2.busy", Busy2,       m2_mode == 1);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_until(input int addr);
    int n = 0;
    while (Prog_addr != addr && n < 40) begin tick(); n++; end
    chk("reach_addr", Prog_addr, addr);
  endtask

  task automatic start_run();
    Start = 1'b1; tick(); Start = 1'b0;
    chk("start.addr", Prog_addr, 0);
    chk("start.busy", Busy, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'h100 | 9'(i & 8'hFF);
    for (int i = 0; i < 16; i++)   rom2[i] = 9'h100 | 9'(i);
    for (int i = 0; i < 32; i++)   lut_m[i] = 0;
    lut_m[2] = 20; lut_m[3] = 6; lut_m[4] = 8;
    rom[5]  = 9'h042;  // BEQ idx 2 -> 20
    rom[7]  = 9'h0C4;  // JMP idx 4 -> 8
    rom[12] = 9'h0FF;  // HALT
    rom[20] = 9'h0C3;  // JMP idx 3 -> 6

    tick(); tick();
    chk("rst.busy",  Busy, 0);
    chk("rst.done",  Done, 0);
    chk("rst.valid", Instr_valid, 0);
    chk("rst.instr", Instruction, 9'h040);
    chk("rst.addr",  Prog_addr, 0);
    Reset_n = 1'b1;

    // Run 1: BEQ taken, stall on a jump, HALT.
    Zero_flag = 1'b1;
    start_run();
    chk("seq.instr0", Instruction, 9'h100);
    chk("seq.valid0", Instr_valid, 1);
    for (int a = 1; a <= 3; a++) begin
      tick(); chk("seq.addr", Prog_addr, a);
      chk("seq.instr", Instruction, 9'h100 | 9'(a));
    end
    run_until(5);
    chk("beq.instr", Instruction, 9'h042);
    tick(); chk("beq_t.addr", Prog_addr, 20);
    tick(); chk("jmp.addr", Prog_addr, 6);
    tick(); chk("pc7.addr", Prog_addr, 7);
    Stall = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall.addr", Prog_addr, 7);
      chk("stall.valid", Instr_valid, 0);
      tick();
    end
    Stall = 1'b0; #1;
    chk("unstall.addr", Prog_addr, 7);
    chk("unstall.valid", Instr_valid, 1);
    tick(); chk("post_stall.addr", Prog_addr, 8);
    run_until(12);
    chk("halt.done", Done, 1);
    tick();
    chk("halted.done",  Done, 0);
    chk("halted.busy",  Busy, 0);
    chk("halted.instr", Instruction, 9'h040);
    chk("halted.addr",  Prog_addr, 12);
    tick(); chk("halted.hold", Prog_addr, 12);

    // Run 2: BEQ not taken.
    Zero_flag = 1'b0;
    start_run();
    run_until(5); tick(); chk("beq_nt.addr", Prog_addr, 6);
    run_until(12); tick();

    // Runs 3 and 4: BNE, outcomes inverted.
    rom[5] = 9'h062;
    start_run();
    run_until(5); tick(); chk("bne_t.addr", Prog_addr, 20);
    run_until(12); tick();
    Zero_flag = 1'b1;
    start_run();
    run_until(5); tick(); chk("bne_nt.addr", Prog_addr, 6);

    // Stall on HALT holds Done low until released.
    run_until(12);
    Stall = 1'b1; #1;
    chk("halt_stall.done", Done, 0);
    tick();
    chk("halt_stall.addr", Prog_addr, 12);
    chk("halt_stall.busy", Busy, 1);
    Stall = 1'b0; #1;
    chk("halt_rel.done", Done, 1);
    tick();

    // Reset mid-run with simultaneous Start.
    start_run();
    run_until(9);
    Reset_n = 1'b0; Start = 1'b1;
    tick();
    Reset_n = 1'b1; Start = 1'b0;
    chk("mid_rst.busy",  Busy, 0);
    chk("mid_rst.addr",  Prog_addr, 0);
    chk("mid_rst.done",  Done, 0);
    chk("mid_rst.instr", Instruction, 9'h040);
    tick();
    chk("mid_rst.idle", Busy, 0);

    // Wrap on the 4-bit instance.
    Start2 = 1'b1; tick(); Start2 = 1'b0;
    chk("wrap.start", Prog_addr2, 0);
    for (int n = 0; n < 20 && Prog_addr2 != 4'd15; n++) tick();
    chk("wrap.at15", Prog_addr2, 15);
    tick();
    chk("wrap.addr", Prog_addr2, 0);
    chk("wrap.done", Done2, 0);
    chk("wrap.busy", Busy2, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
